unsigned_seq_divider_16by8: RTL and testbench
=============================================

// Module: unsigned_seq_divider_16by8
// PURPOSE
//  Iterative restoring divider. It is the inverse of the unsigned 8x8 approximate multiplier family:
//  (dividend 16b) / (divisor 8b) -> 16b quotient + 8b remainder, one quotient bit per clock.
//  Sits behind the multiplier datapath for product checking, normalisation and inverse scaling.
//  Uses a valid/ready handshake on both input and output, so it can be dropped into streaming pipelines.
// PARAMETERS
//  DW   16  dividend and quotient width
//  VW   8   divisor and remainder width
//  L    4   low quotient bits that are truncated (skipped) when APPROX_DIV_EN is defined; 0 <= L < DW
// PORTS
//  clk        in   1   rising-edge clock
//  rst_n      in   1   asynchronous, active-low reset
//  in_valid   in   1   operands valid
//  in_ready   out  1   divider can accept a new operand pair
//  dividend   in   DW  unsigned dividend
//  divisor    in   VW  unsigned divisor
//  out_valid  out  1   result valid; held until it is taken
//  out_ready  in   1   consumer accepts the result
//  quotient   out  DW  unsigned quotient
//  remainder  out  VW  unsigned remainder
//  div0       out  1   divisor was zero for this result
// BEHAVIOUR
//  - Reset (async assert, sync deassert in the system): state=IDLE, in_ready=1, out_valid=0,
//    quotient=0, remainder=0, div0=0.
//  - FSM states and transitions:
//    - IDLE: in_ready=1. When in_valid&in_ready, capture the operands.
//      - divisor==0 -> DIV0
//      - otherwise  -> BUSY, with iteration counter = N-1
//    - BUSY: in_ready=0. Each cycle: rem = {rem[VW-1:0], dividend msb}. If rem >= divisor, then
//      rem -= divisor and shift in a quotient 1; else shift in 0. The partial remainder is VW+1 bits
//      wide, so no overflow is possible. Counter reaches 0 -> DONE.
//    - DIV0: takes one cycle. Sets quotient=all ones, remainder=dividend[VW-1:0], div0=1 -> DONE.
//    - DONE: out_valid=1 and outputs are stable. When out_ready -> IDLE; out_valid drops on the next edge.
//  - N = DW (16) exact. N = DW-L (12) approximate.
//  - Latency: operands accepted at edge k -> out_valid high after edge k+N. Divide-by-zero: after edge k+1.
//  - No new operand is accepted while in BUSY, DIV0 or DONE (in_ready=0).
//    - A result that is taken in DONE gives an IDLE cycle before the next accept.
//    - Throughput is 1 op per N+2 cycles.
//  - out_ready held low in DONE: quotient, remainder and div0 are frozen indefinitely.
//  - in_valid asserted with in_ready=0 is ignored. The producer must hold it.
//  - rst_n asserted mid-BUSY or mid-DONE: the operation is discarded immediately, all outputs take
//    their reset values, and no partial result is ever presented.
//  - Outputs change only on the transition into DONE (or on reset).
// CONFIGURATION
//  - Macro APPROX_DIV_EN.
//  - Defined:
//    - Only the top DW-L iterations run.
//    - quotient[L-1:0] = 0.
//    - quotient[DW-1:L] = (dividend>>L)/divisor.
//    - remainder = (dividend>>L) % divisor.
//    - Latency is DW-L cycles.
//  - Undefined: exact division, all DW iterations; quotient*divisor + remainder == dividend.
//  - Divide-by-zero behaviour is identical in both modes.
// STRUCTURE
//  - Package unsigned_div_pkg holds:
//    - the state enum typedef {IDLE, BUSY, DIV0, DONE};
//    - the localparams for the counter width ($clog2(DW)) and the iteration count N for each mode.
//  - Sub-module div_restore_step, purely combinational:
//    - inputs: (VW+1)-bit partial remainder + next dividend bit, and the divisor;
//    - outputs: the next partial remainder and the quotient bit.
//  - The top level holds the FSM, counter, shift registers and output registers.
// TESTING
//  1. 1000/7, exact: out_valid 16 cycles after accept; q=142, r=6, div0=0.
//  2. 65535/1 and 65535/255: q=65535, r=0 and q=257, r=0. 5/200: q=0, r=5.
//  3. 1234/0: out_valid 1 cycle after accept; q=16'hFFFF, r=8'hD2, div0=1.
//  4. Hold out_ready=0 for 5 cycles in DONE: out_valid and data stay stable, in_ready=0.
//     Then raise out_ready: the next accept happens 2 cycles later.
//  5. Pulse rst_n low at cycle 6 of BUSY: out_valid=0, q=r=0 immediately.
//     A new 1000/7 completes correctly afterwards.
//  6. APPROX_DIV_EN with L=4, 1000/7: out_valid 12 cycles after accept; q=128, r=6.
//     Also run random sweeps against the reference model in both modes.

Source files
------------

// File: rtl/unsigned_div_pkg.sv
// Shared types and constants for the 16/8 sequential restoring divider.
package unsigned_div_pkg;

  localparam int DIV_DW   = 16;
  localparam int DIV_VW   = 8;
  localparam int DIV_L    = 4;
  localparam int CNT_W    = $clog2(DIV_DW);
  localparam int N_EXACT  = DIV_DW;
  localparam int N_APPROX = DIV_DW - DIV_L;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DIV0,
    DONE
  } state_e;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract the divisor if it fits.
module div_restore_step
  import unsigned_div_pkg::*;
#(
  parameter int VW = DIV_VW
) (
  input  logic [VW-1:0] rem_i,
  input  logic          bit_i,
  input  logic [VW-1:0] divisor_i,
  output logic [VW-1:0] rem_o,
  output logic          q_o
);

  logic [VW:0]   shifted;
  logic [VW-1:0] diff;

  // The true difference is below the divisor whenever q_o is set, so VW bits suffice.
  assign shifted = {rem_i, bit_i};
  assign diff    = shifted[VW-1:0] - divisor_i;
  assign q_o     = (shifted >= {1'b0, divisor_i});
  assign rem_o   = q_o ? diff : shifted[VW-1:0];

endmodule

// File: rtl/unsigned_seq_divider_16by8.sv
// Iterative 16/8 unsigned restoring divider with valid/ready on both sides.
// Defining APPROX_DIV_EN skips the low DIV_L quotient bits (they read as zero).
module unsigned_seq_divider_16by8
  import unsigned_div_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DIV_DW-1:0] dividend,
  input  logic [DIV_VW-1:0] divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DIV_DW-1:0] quotient,
  output logic [DIV_VW-1:0] remainder,
  output logic              div0
);

`ifdef APPROX_DIV_EN
  localparam int N = N_APPROX;
`else
  localparam int N = N_EXACT;
`endif
  localparam int QSHIFT = DIV_DW - N;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DIV_VW-1:0] rem_q;
  logic [DIV_DW-1:0] dvd_q;
  logic [DIV_VW-1:0] dsr_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [DIV_DW-1:0] quo_q;
  logic [DIV_VW-1:0] remo_q;
  logic              div0_q;

  logic [DIV_VW-1:0] rem_d;
  logic              qbit_d;
  logic [DIV_DW-1:0] dvd_d;

  div_restore_step #(
    .VW(DIV_VW)
  ) u_step (
    .rem_i    (rem_q),
    .bit_i    (dvd_q[DIV_DW-1]),
    .divisor_i(dsr_q),
    .rem_o    (rem_d),
    .q_o      (qbit_d)
  );

  // Dividend bits leave at the top while quotient bits enter at the bottom.
  assign dvd_d = {dvd_q[DIV_DW-2:0], qbit_d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quo_q       <= '0;
      remo_q      <= '0;
      div0_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            dvd_q      <= dividend;
            dsr_q      <= divisor;
            rem_q      <= '0;
            in_ready_q <= 1'b0;
            if (divisor == '0) begin
              state_q <= DIV0;
            end else begin
              state_q <= BUSY;
              cnt_q   <= CNT_W'(N - 1);
            end
          end
        end
        BUSY: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q - 1'b1;
          // In approximate mode the untouched low dividend bits sit above the quotient and are shifted out.
          if (cnt_q == '0) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            quo_q       <= dvd_d << QSHIFT;
            remo_q      <= rem_d;
            div0_q      <= 1'b0;
          end
        end
        DIV0: begin
          state_q     <= DONE;
          out_valid_q <= 1'b1;
          quo_q       <= '1;
          remo_q      <= dvd_q[DIV_VW-1:0];
          div0_q      <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quotient  = quo_q;
  assign remainder = remo_q;
  assign div0      = div0_q;

endmodule

// File: tb/tb_unsigned_seq_divider_16by8.sv
// Self-checking bench for unsigned_seq_divider_16by8 (exact or APPROX_DIV_EN build).
module tb_unsigned_seq_divider_16by8;

  typedef struct {
    logic [15:0] dvd;
    logic [7:0]  dsr;
    logic [15:0] qEx;
    logic [7:0]  rEx;
    logic [15:0] qAp;
    logic [7:0]  rAp;
    logic        d0;
  } vec_t;

`ifdef APPROX_DIV_EN
  localparam bit APPROX = 1'b1;
  localparam int NITER  = 12;
`else
  localparam bit APPROX = 1'b0;
  localparam int NITER  = 16;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div0;

  int checkCount = 0;
  int passCount  = 0;

  unsigned_seq_divider_16by8 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dividend (dividend),
    .divisor  (divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient (quotient),
    .remainder(remainder),
    .div0     (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic model(input logic [15:0] a, input logic [7:0] b,
                       output logic [15:0] q, output logic [7:0] r, output logic d0, output int lat);
    logic [15:0] aa;
    if (b == 8'd0) begin
      q = 16'hFFFF; r = a[7:0]; d0 = 1'b1; lat = 1;
    end else begin
      aa = APPROX ? (a >> 4) : a;
      q  = APPROX ? ((aa / {8'd0, b}) << 4) : (aa / {8'd0, b});
      r  = 8'(aa % {8'd0, b});
      d0 = 1'b0; lat = NITER;
    end
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] b, output bit ok);
    int waitCycles = 0;
    @(negedge clk);
    dividend = a; divisor = b; in_valid = 1'b1;
    while (!in_ready && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!in_ready) begin
      checkCount++;
      $display("[TB] FAIL accept timeout: in_ready stayed %0b, required 1", in_ready);
      in_valid = 1'b0;
      ok = 1'b0;
    end else begin
      @(posedge clk);
      #1 in_valid = 1'b0;
      ok = 1'b1;
    end
  endtask

  task automatic waitResult(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 40);
  endtask

  task automatic takeResult(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    checkOutput({tag, " valid drop"}, 32'(out_valid), 32'd0);
  endtask

  task automatic runOp(input string tag, input logic [15:0] a, input logic [7:0] b,
                       input logic [15:0] eq, input logic [7:0] er, input logic ed, input int elat);
    bit ok;
    int lat;
    applyStimulus(a, b, ok);
    if (ok) begin
      waitResult(lat);
      checkOutput({tag, " latency"}, 32'(lat), 32'(elat));
      checkOutput({tag, " quotient"}, 32'(quotient), 32'(eq));
      checkOutput({tag, " remainder"}, 32'(remainder), 32'(er));
      checkOutput({tag, " div0"}, 32'(div0), 32'(ed));
      takeResult(tag);
    end
  endtask

  vec_t vecs[9];

  initial begin
    logic [15:0] a, mq;
    logic [7:0]  b, mr;
    logic        md0;
    int          mlat;
    bit          ok;
    int          lat;
    int          edges;
    bit          saw;
    bit          accepted;

    vecs[0] = '{16'd1000,  8'd7,   16'd142,   8'd6,   16'd128,   8'd6,   1'b0};
    vecs[1] = '{16'd65535, 8'd1,   16'd65535, 8'd0,   16'd65520, 8'd0,   1'b0};
    vecs[2] = '{16'd65535, 8'd255, 16'd257,   8'd0,   16'd256,   8'd15,  1'b0};
    vecs[3] = '{16'd5,     8'd200, 16'd0,     8'd5,   16'd0,     8'd0,   1'b0};
    vecs[4] = '{16'd1234,  8'd0,   16'hFFFF,  8'hD2,  16'hFFFF,  8'hD2,  1'b1};
    vecs[5] = '{16'd50000, 8'd123, 16'd406,   8'd62,  16'd400,   8'd50,  1'b0};
    vecs[6] = '{16'd255,   8'd16,  16'd15,    8'd15,  16'd0,     8'd15,  1'b0};
    vecs[7] = '{16'd0,     8'd9,   16'd0,     8'd0,   16'd0,     8'd0,   1'b0};
    vecs[8] = '{16'd40000, 8'd200, 16'd200,   8'd0,   16'd192,   8'd100, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    #12;
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset quotient", 32'(quotient), 32'd0);
    checkOutput("reset remainder", 32'(remainder), 32'd0);
    checkOutput("reset div0", 32'(div0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      runOp($sformatf("vec%0d", i), vecs[i].dvd, vecs[i].dsr,
            APPROX ? vecs[i].qAp : vecs[i].qEx, APPROX ? vecs[i].rAp : vecs[i].rEx,
            vecs[i].d0, vecs[i].d0 ? 1 : NITER);
    end

    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      model(a, b, mq, mr, md0, mlat);
      runOp($sformatf("rand%0d", i), a, b, mq, mr, md0, mlat);
    end

    // Result held in DONE while a new operand waits; then exactly one idle cycle before accept.
    model(16'd50000, 8'd123, mq, mr, md0, mlat);
    applyStimulus(16'd50000, 8'd123, ok);
    waitResult(lat);
    checkOutput("hold latency", 32'(lat), 32'(mlat));
    dividend = 16'd5; divisor = 8'd200; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("hold%0d valid", c), 32'(out_valid), 32'd1);
      checkOutput($sformatf("hold%0d quotient", c), 32'(quotient), 32'(mq));
      checkOutput($sformatf("hold%0d remainder", c), 32'(remainder), 32'(mr));
      checkOutput($sformatf("hold%0d in_ready", c), 32'(in_ready), 32'd0);
    end
    edges = 0; saw = 1'b0; accepted = 1'b0;
    out_ready = 1'b1;
    while (!accepted && edges < 10) begin
      @(posedge clk);
      #1;
      edges++;
      out_ready = 1'b0;
      if (in_ready) saw = 1'b1;
      else if (saw) accepted = 1'b1;
    end
    in_valid = 1'b0;
    checkOutput("accept delay", 32'(edges), 32'd2);
    model(16'd5, 8'd200, mq, mr, md0, mlat);
    waitResult(lat);
    checkOutput("post-hold latency", 32'(lat), 32'(mlat));
    checkOutput("post-hold quotient", 32'(quotient), 32'(mq));
    checkOutput("post-hold remainder", 32'(remainder), 32'(mr));
    takeResult("post-hold");

    // Reset mid-BUSY must clear a previously held result and abort the operation.
    model(16'd1000, 8'd7, mq, mr, md0, mlat);
    runOp("pre-reset", 16'd1000, 8'd7, mq, mr, md0, mlat);
    applyStimulus(16'd1000, 8'd7, ok);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("busy no valid", 32'(out_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset quotient", 32'(quotient), 32'd0);
    checkOutput("midreset remainder", 32'(remainder), 32'd0);
    checkOutput("midreset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    runOp("after-reset", 16'd1000, 8'd7, mq, mr, md0, mlat);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
